// File: rtl/storage_pkg.sv
// Shared constants and state encoding for the button conditioning logic
// that feeds the storage elements (T/D flip-flops, latches).
package storage_pkg;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 50000;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_e;

endpackage

// File: rtl/sync_ff_chain.sv
// Generic multi-flop synchronizer; async active-high reset clears every stage.
module sync_ff_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain_q;
  logic [DEPTH-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[DEPTH-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain_q <= '0;
    else     chain_q <= chain_d;
  end

  assign q = chain_q[DEPTH-1];

endmodule

// File: rtl/debounce_edge_pulse.sv
// Debounces a raw button into a clean registered level plus one-cycle
// rise/fall pulses; a level change needs STABLE_CYCLES equal synced samples.
module debounce_edge_pulse
  import storage_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic sync_in;

  sync_ff_chain #(.DEPTH(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (reset),
    .d   (btn_in),
    .q   (sync_in)
  );

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (sync_in) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        // An opposite sample drops back to idle: glitch rejected, count lost.
        if (!sync_in) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!sync_in) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync_in) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_debounce_edge_pulse.sv
// Randomized and directed checks of debounce_edge_pulse against a run-length
// reference model, plus a downstream T flip-flop driven by rise_pulse.
module tb_debounce_edge_pulse;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 4;
  localparam int CNT_W         = 3;
  localparam int LAT           = SYNC_STAGES + STABLE_CYCLES;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_in = 1'b0;
  logic level_out, rise_pulse, fall_pulse;

  debounce_edge_pulse #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  always #5 clk = ~clk;

  // Downstream consumer: toggles once per rise_pulse.
  logic tff_q;
  always @(posedge clk or posedge reset) begin
    if (reset) tff_q <= 1'b0;
    else if (rise_pulse) tff_q <= ~tff_q;
  end

  int tests = 0;
  int fails = 0;

  // Reference model: btn history delayed by the sync depth, and the length of
  // the current run of samples that disagree with the accepted level.
  bit m_hist[SYNC_STAGES];
  bit m_level, m_rise, m_fall;
  int m_run;

  // Per-scenario observation: edge counter since last stimulus change.
  int edge_n;
  int rise_cnt, fall_cnt, rise_edge, fall_edge;

  task automatic model_clear();
    for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = 1'b0;
    m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
  endtask

  task automatic obs_clear();
    edge_n = 0; rise_cnt = 0; fall_cnt = 0; rise_edge = -1; fall_edge = -1;
  endtask

  task automatic step();
    bit s;
    @(posedge clk);
    edge_n++;
    if (reset) begin
      model_clear();
    end else begin
      s = m_hist[SYNC_STAGES-1];
      for (int i = SYNC_STAGES - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = btn_in;
      m_rise = 1'b0; m_fall = 1'b0;
      if (s != m_level) begin
        m_run++;
        if (m_run == STABLE_CYCLES) begin
          m_level = s; m_rise = s; m_fall = !s; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    #1;
    tests++;
    if ({level_out, rise_pulse, fall_pulse} !== {m_level, m_rise, m_fall}) begin
      fails++;
      $display("FAIL model edge=%0d: got lvl/rise/fall=%b%b%b want %b%b%b at %0t",
               edge_n, level_out, rise_pulse, fall_pulse, m_level, m_rise, m_fall, $time);
    end
    if (rise_pulse === 1'b1) begin rise_cnt++; rise_edge = edge_n; end
    if (fall_pulse === 1'b1) begin fall_cnt++; fall_edge = edge_n; end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    model_clear();
    btn_in = 1'b1;
    #1 reset = 1'b1;
    #1;
    tests++;
    if ({level_out, rise_pulse, fall_pulse} !== 3'b000) begin
      fails++;
      $display("FAIL reset_init: got %b%b%b want 000", level_out, rise_pulse, fall_pulse);
    end
    obs_clear();
    steps(3);
    #2 reset = 1'b0;
    obs_clear();
    steps(12);
    tests++;
    if (rise_cnt != 1 || rise_edge != LAT || fall_cnt != 0) begin
      fails++;
      $display("FAIL reset_held: rises=%0d at edge %0d falls=%0d want 1 at %0d, 0",
               rise_cnt, rise_edge, fall_cnt, LAT);
    end
  endtask

  task automatic test_clean_press();
    btn_in = 1'b0;
    steps(12);
    btn_in = 1'b1;
    obs_clear();
    steps(20);
    tests++;
    if (rise_cnt != 1 || rise_edge != LAT || level_out !== 1'b1) begin
      fails++;
      $display("FAIL press: rises=%0d at edge %0d lvl=%b want 1 at %0d lvl=1",
               rise_cnt, rise_edge, level_out, LAT);
    end
    btn_in = 1'b0;
    obs_clear();
    steps(20);
    tests++;
    if (fall_cnt != 1 || fall_edge != LAT || rise_cnt != 0 || level_out !== 1'b0) begin
      fails++;
      $display("FAIL release: falls=%0d at edge %0d rises=%0d lvl=%b want 1 at %0d, 0, lvl=0",
               fall_cnt, fall_edge, rise_cnt, level_out, LAT);
    end
  endtask

  task automatic test_bounce();
    bit seq[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    obs_clear();
    for (int i = 0; i < 8; i++) begin
      btn_in = seq[i];
      step();
    end
    tests++;
    if (rise_cnt != 0 || fall_cnt != 0) begin
      fails++;
      $display("FAIL bounce_quiet: rises=%0d falls=%0d want 0 0", rise_cnt, fall_cnt);
    end
    btn_in = 1'b1;
    obs_clear();
    steps(20);
    tests++;
    if (rise_cnt != 1 || rise_edge != LAT || fall_cnt != 0) begin
      fails++;
      $display("FAIL bounce_settle: rises=%0d at edge %0d falls=%0d want 1 at %0d, 0",
               rise_cnt, rise_edge, fall_cnt, LAT);
    end
    btn_in = 1'b0;
    steps(20);
  endtask

  task automatic test_glitch();
    obs_clear();
    btn_in = 1'b1;
    steps(3);
    btn_in = 1'b0;
    steps(15);
    tests++;
    if (rise_cnt != 0 || fall_cnt != 0 || level_out !== 1'b0) begin
      fails++;
      $display("FAIL glitch: rises=%0d falls=%0d lvl=%b want 0 0 0",
               rise_cnt, fall_cnt, level_out);
    end
  endtask

  task automatic test_async_reset();
    // Partial count: sample, sync, then cnt=1, cnt=2 in WAIT_HIGH.
    btn_in = 1'b1;
    steps(SYNC_STAGES + 2);
    #2 reset = 1'b1;
    model_clear();
    #1;
    tests++;
    if ({level_out, rise_pulse, fall_pulse} !== 3'b000) begin
      fails++;
      $display("FAIL areset_mid: got %b%b%b want 000", level_out, rise_pulse, fall_pulse);
    end
    @(negedge clk) reset = 1'b0;
    obs_clear();
    steps(12);
    tests++;
    if (rise_cnt != 1 || rise_edge != LAT) begin
      fails++;
      $display("FAIL areset_restart: rises=%0d at edge %0d want 1 at %0d",
               rise_cnt, rise_edge, LAT);
    end
    // Reset while the level is high must drop it without a clock edge.
    #2 reset = 1'b1;
    model_clear();
    #1;
    tests++;
    if (level_out !== 1'b0) begin
      fails++;
      $display("FAIL areset_high: lvl=%b want 0", level_out);
    end
    btn_in = 1'b0;
    @(negedge clk) reset = 1'b0;
    steps(4);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      // Mix short bursts (bounce) with longer holds.
      btn_in = 1'($urandom_range(0, 1));
      steps($urandom_range(0, 3) == 0 ? int'($urandom_range(5, 12)) : int'($urandom_range(1, 3)));
    end
    btn_in = 1'b0;
    steps(12);
  endtask

  task automatic test_tff();
    bit exp_t;
    #2 reset = 1'b1;
    model_clear();
    btn_in = 1'b0;
    @(negedge clk) reset = 1'b0;
    exp_t = 1'b0;
    tests++;
    if (tff_q !== exp_t) begin
      fails++;
      $display("FAIL tff_init: got %b want %b", tff_q, exp_t);
    end
    for (int p = 0; p < 3; p++) begin
      btn_in = 1'b1;
      steps(10);
      btn_in = 1'b0;
      steps(10);
      exp_t = ~exp_t;
      tests++;
      if (tff_q !== exp_t) begin
        fails++;
        $display("FAIL tff_press%0d: got %b want %b", p, tff_q, exp_t);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_async_reset();
    test_random();
    test_tff();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
